// File: rtl/memoria_unit.sv
`default_nettype none
// ============================================================================
// Module      : memoria_unit
// Description : 2**ADDR_W x WIDTH register-array memory with two
//               combinational read ports and one synchronous write port.
//               The write port shares its address (ind1) with read port 1.
//               reset clears every word asynchronously; writes are ignored
//               while it is asserted.
//               Optional macro MEMORIA_BYPASS_EN: a read port whose address
//               matches the pending write shows x before the edge
//               (write-first forwarding). Without it, read ports show only
//               stored contents.
// Revision    : 1.0 - initial release
// ============================================================================
module memoria_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 10
) (
    output logic [WIDTH-1:0]  out1,
    output logic [WIDTH-1:0]  out2,
    input  logic [WIDTH-1:0]  x,
    input  logic [ADDR_W-1:0] ind1,
    input  logic [ADDR_W-1:0] ind2,
    input  logic              clock,
    input  logic              beta,
    input  logic              reset
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] r_mem [c_DEPTH];

    // One write-decode per word keeps the asynchronous clear a plain
    // per-register reset rather than a loop inside a single process.
    for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_word
        // Word storage: cleared by reset, loaded with x when addressed by a write
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_mem[gi] <= '0;
            end else if (beta && (ind1 == ADDR_W'(gi))) begin
                r_mem[gi] <= x;
            end
        end
    end

`ifdef MEMORIA_BYPASS_EN
    // Forwarding is suppressed during reset so outputs read the cleared
    // contents, matching the fact that the write itself will be dropped.
    logic w_fwd1;
    logic w_fwd2;

    assign w_fwd1 = beta && !reset;
    assign w_fwd2 = beta && !reset && (ind2 == ind1);

    // Read ports with write-first forwarding of the pending write data
    always_comb begin
        out1 = w_fwd1 ? x : r_mem[ind1];
        out2 = w_fwd2 ? x : r_mem[ind2];
    end
`else
    // Read ports show stored contents only (read-before-write)
    always_comb begin
        out1 = r_mem[ind1];
        out2 = r_mem[ind2];
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_memoria_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_memoria_unit
// Description : Directed self-checking bench for memoria_unit. Expected
//               values are hand-computed; pre-edge values during a write
//               depend on whether MEMORIA_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memoria_unit;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 10;

`ifdef MEMORIA_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic [WIDTH-1:0]  out1;
    logic [WIDTH-1:0]  out2;
    logic [WIDTH-1:0]  x;
    logic [ADDR_W-1:0] ind1;
    logic [ADDR_W-1:0] ind2;
    logic              clock;
    logic              beta;
    logic              reset;

    int total = 0;
    int bad   = 0;

    memoria_unit #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_dut (
        .out1  (out1),
        .out2  (out2),
        .x     (x),
        .ind1  (ind1),
        .ind2  (ind2),
        .clock (clock),
        .beta  (beta),
        .reset (reset)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        beta  = 1'b0;
        x     = '0;
        ind1  = 10'd0;
        ind2  = 10'd1023;
        #3;
        chk("rst_out1", out1, 32'd0);
        chk("rst_out2", out2, 32'd0);
        #9;                      // t=12, between edges
        reset = 1'b0;
        #1;
        chk("post_rst_out1", out1, 32'd0);
        chk("post_rst_out2", out2, 32'd0);

        // Write 42 to address 0, both ports on address 0
        tick();
        x = 32'd42; ind1 = 10'd0; ind2 = 10'd0; beta = 1'b1;
        #1;
        chk("w42_pre_out1", out1, c_BYP ? 32'd42 : 32'd0);
        chk("w42_pre_out2", out2, c_BYP ? 32'd42 : 32'd0);
        tick();
        chk("w42_out1", out1, 32'd42);
        chk("w42_out2", out2, 32'd42);

        // Overwrite address 0 with 128, port 2 on the top address
        x = 32'd128; ind1 = 10'd0; ind2 = 10'd1023;
        #1;
        chk("w128_pre_out2", out2, 32'd0);
        tick();
        chk("w128_out1", out1, 32'd128);
        chk("w128_out2", out2, 32'd0);

        // Write 256 to the top address, port 2 still watching it
        x = 32'd256; ind1 = 10'd1023;
        #1;
        chk("w256_pre_out1", out1, c_BYP ? 32'd256 : 32'd0);
        chk("w256_pre_out2", out2, c_BYP ? 32'd256 : 32'd0);
        tick();
        chk("w256_out1", out1, 32'd256);
        chk("w256_out2", out2, 32'd256);

        // beta=0: several edges must not change address 5
        beta = 1'b0; x = 32'hDEADBEEF; ind1 = 10'd5; ind2 = 10'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("nowr_pre_out1", out1, 32'd0);
            tick();
            chk("nowr_post_out1", out1, 32'd0);
        end
        chk("nowr_addr0_kept", out2, 32'd128);
        ind2 = 10'd1023;
        #1;
        chk("nowr_top_kept", out2, 32'd256);

        // All-ones word at address 7, then asynchronous clear
        tick();
        beta = 1'b1; x = 32'hFFFFFFFF; ind1 = 10'd7; ind2 = 10'd7;
        tick();
        beta = 1'b0;
        #1;
        chk("ones_out1", out1, 32'hFFFFFFFF);
        chk("ones_out2", out2, 32'hFFFFFFFF);
        #1;
        reset = 1'b1;            // mid-cycle, no clock edge involved
        #1;
        chk("async_clr_out1", out1, 32'd0);
        chk("async_clr_out2", out2, 32'd0);
        ind2 = 10'd1023;
        #1;
        chk("async_clr_top", out2, 32'd0);

        // A write attempt during reset is dropped
        beta = 1'b1; x = 32'hFFFFFFFF; ind1 = 10'd7; ind2 = 10'd7;
        #1;
        chk("rst_wr_pre_out1", out1, 32'd0);
        tick();
        chk("rst_wr_out1", out1, 32'd0);
        chk("rst_wr_out2", out2, 32'd0);
        beta = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rst_rel_out1", out1, 32'd0);

        // First write after release is a normal write
        beta = 1'b1; x = 32'h0000_1234;
        tick();
        beta = 1'b0;
        #1;
        chk("first_wr_out1", out1, 32'h0000_1234);

        // Forwarding check on address 3 holding 0x11
        beta = 1'b1; x = 32'h11; ind1 = 10'd3; ind2 = 10'd4;
        tick();
        x = 32'h55; ind2 = 10'd3;
        #1;
        chk("fwd_pre_out1", out1, c_BYP ? 32'h55 : 32'h11);
        chk("fwd_pre_out2", out2, c_BYP ? 32'h55 : 32'h11);
        ind2 = 10'd4;
        #1;
        chk("fwd_other_out2", out2, 32'd0);
        ind2 = 10'd3;
        tick();
        beta = 1'b0;
        #1;
        chk("fwd_post_out1", out1, 32'h55);
        chk("fwd_post_out2", out2, 32'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/memoria_unit.md
MEMORIA_UNIT -- requirements
Module: memoria_unit

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter ADDR_W, default 10, address width; depth = 2**ADDR_W (1024 words).
REQ-003 clock  input  1  single clock; all state changes on its rising edge, except reset.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 out1  output  WIDTH  read data, port 1 (addressed by ind1).
REQ-006 out2  output  WIDTH  read data, port 2 (addressed by ind2).
REQ-007 x  input  WIDTH  write data.
REQ-008 ind1  input  ADDR_W  address for read port 1 and for the write port.
REQ-009 ind2  input  ADDR_W  address for read port 2 (read-only).
REQ-010 beta  input  1  write enable, active-high.
REQ-011 Port declaration order SHALL be out1, out2, x, ind1, ind2, clock, beta, reset, so positional instances of the original seven ports remain valid.

Function
REQ-012 Storage SHALL be a 2**ADDR_W x WIDTH register array: two read ports, one write port.
REQ-013 On a rising clock edge with beta=1 and reset=0, mem[ind1] SHALL be loaded with x.
REQ-014 With beta=0, no word SHALL change on a clock edge.
REQ-015 out1 SHALL equal mem[ind1] and out2 SHALL equal mem[ind2] combinationally (zero-cycle read latency, no read enable).
REQ-016 A written value SHALL be visible on any read port addressing that word immediately after the writing edge.
REQ-017 ind1 == ind2 SHALL be legal; both outputs then show the same word.
REQ-018 Addresses 0 and 2**ADDR_W-1 SHALL be fully usable; every ADDR_W-bit value is in range; no wrap or error logic.
REQ-019 Write data SHALL be stored unmodified at full WIDTH; no sign extension or truncation.

Reset
REQ-020 reset=1 SHALL clear every word to 0 immediately, independent of clock; out1 and out2 SHALL then read 0.
REQ-021 While reset=1, writes SHALL be ignored, including beta=1 at a clock edge.
REQ-022 After reset deasserts, the first rising clock edge with beta=1 SHALL perform a normal write.

Configuration
REQ-023 Macro MEMORIA_BYPASS_EN defined: when beta=1 and a read address equals ind1, that read port SHALL output x (write-first forwarding) before the edge; this is always the case for out1, and for out2 when ind2==ind1.
REQ-024 Macro MEMORIA_BYPASS_EN undefined: read ports SHALL show only stored contents (read-before-write); x reaches the outputs only after the writing edge.
REQ-025 Behaviour per REQ-012..022 SHALL be identical in both builds, except for pre-edge output values during a write.

Verification
REQ-026 Pulse reset; then read with ind1=0, ind2=1023 -> out1=0, out2=0.
REQ-027 x=42, ind1=0, ind2=0, beta=1, one edge -> out1=42, out2=42.
REQ-028 beta=1, x=128, ind1=0, ind2=1023, one edge -> out1=128, out2=0; then ind1=1023, x=256, one edge -> out1=256, out2=256.
REQ-029 beta=0, x=0xDEADBEEF, ind1=5, several edges -> mem[5] unchanged (0 after reset); without bypass, out1=0 before and after each edge.
REQ-030 Write 0xFFFFFFFF to address 7, then assert reset between edges -> out1 with ind1=7 reads 0 at once; a beta=1 edge during reset leaves 0.
REQ-031 Bypass build: beta=1, ind1=ind2=3, x=0x55 before the edge -> out1=out2=0x55; non-bypass build -> old value until the edge.
